zircon_avalon_buzzer_sequencer: RTL and testbench
=================================================

// Module: zircon_avalon_buzzer_sequencer
// PURPOSE
//  Upstream note sequencer for the buzzer PWM stage. The CPU queues notes over Avalon-MM.
//  Each note is a PWM period plus a duration in ms. The block plays queued notes back to
//  back and drives pwm_enable/pwm_clock_divide/pwm_duty_cycle of the PWM logic directly.
//  A fixed silent gap separates consecutive notes.
// PARAMETERS
//  FIFO_DEPTH  8      note FIFO entries (power of 2, >=2)
//  TICK_DIV    50000  csi_clk cycles per ms tick (50 MHz -> 1 ms)
//  GAP_MS      10     silent ticks between notes (0 = no gap state)
// PORTS
//  csi_clk           in   1   system clock
//  rsi_reset         in   1   synchronous reset, active-high
//  avs_address       in   2   register select
//  avs_write         in   1   write strobe
//  avs_writedata     in   32  write data
//  avs_read          in   1   read strobe
//  avs_readdata      out  32  read data, 1-cycle latency
//  pwm_enable        out  1   to PWM stage; 1 while a tone sounds
//  pwm_clock_divide  out  32  to PWM stage; current note period
//  pwm_duty_cycle    out  32  to PWM stage; period>>1 (50 % duty)
//  seq_busy          out  1   FSM not in IDLE
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; FSM IDLE; run=0; overflow=0; staged period=0.
//  Register map:
//   0 W  PERIOD staging reg [31:0]. Read returns staged value.
//   1 W  PUSH: writes {PERIOD, writedata[15:0]=dur_ms} into FIFO. Read returns 0.
//   2 RW CONTROL: b0 run; b1 flush (self-clearing, reads 0); b2 clr_ovf (self-clearing).
//   3 R  STATUS: b0 busy, b1 full, b2 empty, b3 overflow(sticky), [15:8] fill level.
//  PUSH while full: entry dropped, overflow set. clr_ovf and a set in the same cycle -> set wins.
//  FSM states and transitions:
//   IDLE: run && !empty -> LOAD (pop in same cycle).
//   LOAD: one cycle; latch divide/duty; load ms_cnt=max(dur,1); clear prescaler -> PLAY.
//   PLAY: pwm_enable=(period!=0); period 0 means rest. Prescaler counts 0..TICK_DIV-1.
//         Each wrap decrements ms_cnt. Wrap with ms_cnt==1 -> GAP, or IDLE if GAP_MS==0.
//         PLAY therefore lasts exactly max(dur,1)*TICK_DIV cycles.
//   GAP:  pwm_enable=0, divide/duty held; GAP_MS ticks -> IDLE.
//         From IDLE the next note reaches LOAD the following cycle.
//  pwm_* outputs are registered. pwm_enable rises on the cycle after LOAD.
//  run cleared in any state -> IDLE next cycle; pwm_enable=0; current note is discarded.
//  flush -> FIFO emptied and FSM to IDLE same cycle; if a PUSH coincides, flush wins.
//  Simultaneous PUSH and pop on a full FIFO: the pop frees a slot, the push is accepted,
//  no overflow.
//  Fill level width is clog2(FIFO_DEPTH)+1 bits, zero-extended into [15:8].
// CONFIGURATION
//  BUZZER_SEQ_IRQ_EN defined: adds port ins_irq (out, 1) and CONTROL b3 irq_en.
//   ins_irq is a level: irq_en && empty && FSM IDLE && run (queue drained).
//   The CPU clears it by pushing a note or clearing run/irq_en.
//  Undefined: no ins_irq port; CONTROL b3 reads 0, writes ignored.
// STRUCTURE
//  Package zircon_buzzer_pkg:
//   register address constants (REG_PERIOD/PUSH/CONTROL/STATUS)
//   CONTROL/STATUS bit indices
//   FSM state encoding (S_IDLE, S_LOAD, S_PLAY, S_GAP)
//   note entry width (48)
//  Sub-module zircon_buzzer_note_fifo: synchronous FIFO, 48-bit x FIFO_DEPTH.
//   Signals: push/pop/flush, full/empty/level; show-ahead read data.
//  Top level holds the register file, prescaler, ms counter, FSM and output registers.
// TESTING (TICK_DIV=10, GAP_MS=2, FIFO_DEPTH=4)
//  Reset: all pwm_* = 0, STATUS = 0x00000004.
//  PERIOD=1000, PUSH dur=3, run=1 -> divide=1000, duty=500, pwm_enable=1 for exactly
//   30 cycles; then 0 for 20 cycles; seq_busy falls after that.
//  5 PUSHes with run=0 -> STATUS b1=1, b3=1, level=4.
//   clr_ovf clears b3; FIFO contents unchanged.
//  Note PERIOD=0 dur=2 -> pwm_enable stays 0 for 20 cycles; busy=1 throughout.
//  Mid-PLAY run=0 -> pwm_enable=0 next cycle, FSM IDLE.
//   Mid-PLAY flush -> STATUS empty=1 and busy=0 next cycle.
//  PUSH dur=0 -> plays 10 cycles (treated as 1 ms).
//   IRQ_EN build: ins_irq=1 after queue drains with irq_en=1; 0 after the next PUSH.

Source files
------------

// File: rtl/zircon_buzzer_pkg.sv
// Shared constants for the buzzer note sequencer: register map, bit indices,
// FSM encoding and note entry layout {period[31:0], dur_ms[15:0]}.
package zircon_buzzer_pkg;

  localparam logic [1:0] REG_PERIOD  = 2'd0;
  localparam logic [1:0] REG_PUSH    = 2'd1;
  localparam logic [1:0] REG_CONTROL = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  localparam int CTRL_RUN     = 0;
  localparam int CTRL_FLUSH   = 1;
  localparam int CTRL_CLR_OVF = 2;
  localparam int CTRL_IRQ_EN  = 3;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_EMPTY     = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_LEVEL_LSB = 8;

  localparam int PERIOD_W = 32;
  localparam int DUR_W    = 16;
  localparam int NOTE_W   = PERIOD_W + DUR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2,
    S_GAP  = 2'd3
  } seq_state_e;

  // A zero duration still plays for one tick.
  function automatic logic [DUR_W-1:0] eff_dur(input logic [DUR_W-1:0] dur);
    return (dur == '0) ? DUR_W'(1) : dur;
  endfunction

endpackage

// File: rtl/zircon_buzzer_note_fifo.sv
// Synchronous show-ahead note FIFO. Flush beats push; a pop on a full FIFO
// frees the slot for a push in the same cycle.
module zircon_buzzer_note_fifo
  import zircon_buzzer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push_i,
  input  logic [NOTE_W-1:0]       wdata_i,
  input  logic                    pop_i,
  input  logic                    flush_i,
  output logic [NOTE_W-1:0]       rdata_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [NOTE_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              do_push, do_pop;

  assign level_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (level_o == FULL_LVL);
  assign empty_o = (level_o == '0);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && !flush_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/zircon_avalon_buzzer_sequencer.sv
// Avalon-MM note sequencer feeding the buzzer PWM stage. Optional drained-queue
// interrupt (ins_irq, CONTROL b3) is built when BUZZER_SEQ_IRQ_EN is defined.
module zircon_avalon_buzzer_sequencer
  import zircon_buzzer_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int TICK_DIV   = 50000,
  parameter int GAP_MS     = 10
) (
  input  logic        csi_clk,
  input  logic        rsi_reset,
  input  logic [1:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        pwm_enable,
  output logic [31:0] pwm_clock_divide,
  output logic [31:0] pwm_duty_cycle,
  output logic        seq_busy
`ifdef BUZZER_SEQ_IRQ_EN
  ,
  output logic        ins_irq
`endif
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0] GAP_TICKS = DUR_W'(GAP_MS);

  seq_state_e        state_q, state_d;
  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [DUR_W-1:0]  ms_cnt_q, ms_cnt_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [31:0]       period_q, period_d;
  logic              run_q, run_d;
  logic              ovf_q, ovf_d;
  logic              en_q, en_d;
  logic [31:0]       div_q, div_d;
  logic [31:0]       duty_q, duty_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              wr_period, wr_push, wr_ctrl;
  logic              flush, clr_ovf, ovf_set, pop;
  logic [NOTE_W-1:0] fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic [LVL_W-1:0]  fifo_level;
  logic [31:0]       note_period;

  assign wr_period   = avs_write && (avs_address == REG_PERIOD);
  assign wr_push     = avs_write && (avs_address == REG_PUSH);
  assign wr_ctrl     = avs_write && (avs_address == REG_CONTROL);
  assign flush       = wr_ctrl && avs_writedata[CTRL_FLUSH];
  assign clr_ovf     = wr_ctrl && avs_writedata[CTRL_CLR_OVF];
  assign run_d       = wr_ctrl ? avs_writedata[CTRL_RUN] : run_q;
  assign period_d    = wr_period ? avs_writedata : period_q;
  assign note_period = note_q[NOTE_W-1:DUR_W];

  zircon_buzzer_note_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (csi_clk),
    .rst_i   (rsi_reset),
    .push_i  (wr_push),
    .wdata_i ({period_q, avs_writedata[DUR_W-1:0]}),
    .pop_i   (pop),
    .flush_i (flush),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // A dropped push only counts when no pop frees a slot and no flush overrides it.
  assign ovf_set = wr_push && fifo_full && !pop && !flush;
  assign ovf_d   = ovf_set ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    ms_cnt_d = ms_cnt_q;
    note_d   = note_q;
    pop      = 1'b0;
    if (flush || !run_d) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            state_d = S_LOAD;
            pop     = 1'b1;
            note_d  = fifo_rdata;
          end
        end
        S_LOAD: begin
          state_d  = S_PLAY;
          ms_cnt_d = eff_dur(note_q[DUR_W-1:0]);
          presc_d  = '0;
        end
        S_PLAY: begin
          if (presc_q == PRE_MAX) begin
            presc_d = '0;
            if (ms_cnt_q == DUR_W'(1)) begin
              if (GAP_MS == 0) begin
                state_d = S_IDLE;
              end else begin
                state_d  = S_GAP;
                ms_cnt_d = GAP_TICKS;
              end
            end else begin
              ms_cnt_d = ms_cnt_q - 1'b1;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        S_GAP: begin
          if (presc_q == PRE_MAX) begin
            presc_d = '0;
            if (ms_cnt_q == DUR_W'(1)) state_d = S_IDLE;
            else                       ms_cnt_d = ms_cnt_q - 1'b1;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Divide/duty latch on the LOAD->PLAY edge and hold through GAP and IDLE.
  always_comb begin
    div_d  = div_q;
    duty_d = duty_q;
    en_d   = (state_d == S_PLAY) && (note_period != '0);
    if ((state_q == S_LOAD) && (state_d == S_PLAY)) begin
      div_d  = note_period;
      duty_d = note_period >> 1;
    end
  end

`ifdef BUZZER_SEQ_IRQ_EN
  logic irq_en_q, irq_en_d;

  assign irq_en_d = wr_ctrl ? avs_writedata[CTRL_IRQ_EN] : irq_en_q;
  assign ins_irq  = irq_en_q && fifo_empty && (state_q == S_IDLE) && run_q;

  always_ff @(posedge csi_clk) begin
    if (rsi_reset) irq_en_q <= 1'b0;
    else           irq_en_q <= irq_en_d;
  end
`endif

  always_comb begin
    rdata_d = '0;
    if (avs_read) begin
      case (avs_address)
        REG_PERIOD: rdata_d = period_q;
        REG_PUSH:   rdata_d = '0;
        REG_CONTROL: begin
          rdata_d[CTRL_RUN] = run_q;
`ifdef BUZZER_SEQ_IRQ_EN
          rdata_d[CTRL_IRQ_EN] = irq_en_q;
`endif
        end
        REG_STATUS: begin
          rdata_d[STAT_BUSY]                  = (state_q != S_IDLE);
          rdata_d[STAT_FULL]                  = fifo_full;
          rdata_d[STAT_EMPTY]                 = fifo_empty;
          rdata_d[STAT_OVF]                   = ovf_q;
          rdata_d[STAT_LEVEL_LSB +: LVL_W]    = fifo_level;
        end
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge csi_clk) begin
    if (rsi_reset) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      ms_cnt_q <= '0;
      note_q   <= '0;
      period_q <= '0;
      run_q    <= 1'b0;
      ovf_q    <= 1'b0;
      en_q     <= 1'b0;
      div_q    <= '0;
      duty_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      ms_cnt_q <= ms_cnt_d;
      note_q   <= note_d;
      period_q <= period_d;
      run_q    <= run_d;
      ovf_q    <= ovf_d;
      en_q     <= en_d;
      div_q    <= div_d;
      duty_q   <= duty_d;
      rdata_q  <= rdata_d;
    end
  end

  assign avs_readdata     = rdata_q;
  assign pwm_enable       = en_q;
  assign pwm_clock_divide = div_q;
  assign pwm_duty_cycle   = duty_q;
  assign seq_busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_zircon_avalon_buzzer_sequencer.sv
// Bench for the buzzer sequencer: timeline model of note playback plus directed
// register-level scenarios with literal expectations.
module tb_zircon_avalon_buzzer_sequencer;

  localparam int TICK  = 10;
  localparam int GAPC  = 2 * TICK;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  avs_address;
  logic        avs_write, avs_read;
  logic [31:0] avs_writedata, avs_readdata;
  logic        pwm_enable, seq_busy;
  logic [31:0] pwm_clock_divide, pwm_duty_cycle;
`ifdef BUZZER_SEQ_IRQ_EN
  logic        ins_irq;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  zircon_avalon_buzzer_sequencer #(
    .FIFO_DEPTH (DEPTH),
    .TICK_DIV   (TICK),
    .GAP_MS     (2)
  ) dut (
    .csi_clk          (clk),
    .rsi_reset        (rst),
    .avs_address      (avs_address),
    .avs_write        (avs_write),
    .avs_writedata    (avs_writedata),
    .avs_read         (avs_read),
    .avs_readdata     (avs_readdata),
    .pwm_enable       (pwm_enable),
    .pwm_clock_divide (pwm_clock_divide),
    .pwm_duty_cycle   (pwm_duty_cycle),
    .seq_busy         (seq_busy)
`ifdef BUZZER_SEQ_IRQ_EN
    ,
    .ins_irq          (ins_irq)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: queue of notes plus time-since-start of the current note.
  // Timeline of a note with effective duration D: t=0 load, t=1..10D tone,
  // then 20 silent cycles, idle again at t=10D+21.
  logic [47:0] m_q[$];
  bit          m_started = 1'b0;
  bit          m_run, m_ovf, m_irq_en, m_active, m_rd_valid;
  int          m_t, m_cur_dur;
  logic [31:0] m_stage, m_cur_per, m_div, m_rdata;

  function automatic logic [31:0] m_status();
    int sz;
    sz = m_q.size();
    return {16'd0, 8'(sz), 4'd0, m_ovf, (sz == 0), (sz == DEPTH), m_active};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_q.delete();
        m_started = 1'b1; m_run = 1'b0; m_ovf = 1'b0; m_irq_en = 1'b0;
        m_active = 1'b0; m_rd_valid = 1'b0; m_t = 0; m_cur_dur = 1;
        m_stage = '0; m_cur_per = '0; m_div = '0; m_rdata = '0;
      end else begin
        bit wr_ctrl, flush, clr, run_n, push, pop, set;
        int pre_size;
        m_rd_valid = avs_read;
        m_rdata    = '0;
        if (avs_read) begin
          case (avs_address)
            2'd0: m_rdata = m_stage;
            2'd2: m_rdata = {28'd0, m_irq_en, 2'b00, m_run};
            2'd3: m_rdata = m_status();
            default: m_rdata = '0;
          endcase
        end
        wr_ctrl  = avs_write && (avs_address == 2'd2);
        flush    = wr_ctrl && avs_writedata[1];
        clr      = wr_ctrl && avs_writedata[2];
        run_n    = wr_ctrl ? avs_writedata[0] : m_run;
        push     = avs_write && (avs_address == 2'd1);
        pre_size = m_q.size();
        pop      = 1'b0;
        set      = 1'b0;
        if (m_active) begin
          if (flush || !run_n) m_active = 1'b0;
          else begin
            m_t++;
            if (m_t == 1) m_div = m_cur_per;
            if (m_t > TICK * m_cur_dur + GAPC) m_active = 1'b0;
          end
        end else if (run_n && !flush && pre_size > 0) begin
          pop       = 1'b1;
          m_active  = 1'b1;
          m_t       = 0;
          m_cur_per = m_q[0][47:16];
          m_cur_dur = (m_q[0][15:0] == 16'd0) ? 1 : int'(m_q[0][15:0]);
        end
        if (flush) m_q.delete();
        else begin
          if (pop) m_q.delete(0);
          if (push) begin
            if (pre_size == DEPTH && !pop) set = 1'b1;
            else m_q.push_back({m_stage, avs_writedata[15:0]});
          end
        end
        m_ovf = set ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_run = run_n;
`ifdef BUZZER_SEQ_IRQ_EN
        if (wr_ctrl) m_irq_en = avs_writedata[3];
`endif
        if (avs_write && avs_address == 2'd0) m_stage = avs_writedata;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (m_started) begin
        bit exp_en;
        exp_en = m_active && (m_t >= 1) && (m_t <= TICK * m_cur_dur) && (m_cur_per != 0);
        chk("busy", 32'(seq_busy), 32'(m_active));
        chk("pwm_enable", 32'(pwm_enable), 32'(exp_en));
        chk("divide", pwm_clock_divide, m_div);
        chk("duty", pwm_duty_cycle, m_div >> 1);
        if (m_rd_valid) chk("readdata", avs_readdata, m_rdata);
`ifdef BUZZER_SEQ_IRQ_EN
        chk("irq", 32'(ins_irq), 32'(m_irq_en && m_q.size() == 0 && !m_active && m_run));
`endif
      end
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic measure(output int hi, output int lo, output logic [31:0] dv, output logic [31:0] dt);
    int n;
    n = 0; hi = 0; lo = 0;
    while (!pwm_enable && n < 100) begin @(negedge clk); n++; end
    dv = pwm_clock_divide; dt = pwm_duty_cycle;
    while (pwm_enable && hi < 200) begin hi++; @(negedge clk); end
    while (seq_busy && lo < 200) begin lo++; @(negedge clk); end
  endtask

  task automatic measure_busy(output int busy_n, output int en_n);
    int n;
    n = 0; busy_n = 0; en_n = 0;
    while (!seq_busy && n < 100) begin @(negedge clk); n++; end
    while (seq_busy && busy_n < 300) begin
      busy_n++;
      if (pwm_enable) en_n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, lo, n;
    logic [31:0] dv, dt;
    rst = 1'b1; avs_address = '0; avs_write = 1'b0; avs_read = 1'b0; avs_writedata = '0;
    repeat (3) @(negedge clk);
    chk("rst_enable", 32'(pwm_enable), 32'd0);
    chk("rst_divide", pwm_clock_divide, 32'd0);
    chk("rst_busy", 32'(seq_busy), 32'd0);
    rst = 1'b0;
    rd(2'd3); chk("rst_status", avs_readdata, 32'h4);

    // Single note: 1000 period, 3 ms.
    wr(2'd0, 32'd1000);
    rd(2'd0); chk("period_readback", avs_readdata, 32'd1000);
    wr(2'd1, 32'd3);
    wr(2'd2, 32'd1);
    measure(hi, lo, dv, dt);
    chk("tone_div", dv, 32'd1000);
    chk("tone_duty", dt, 32'd500);
    chk("tone_len", hi, 32'd30);
    chk("gap_len", lo, 32'd20);

    // Overflow with run=0, then clear it and play the kept four.
    wr(2'd2, 32'd0);
    wr(2'd0, 32'd100); wr(2'd1, 32'd1);
    wr(2'd0, 32'd0);   wr(2'd1, 32'd2);
    wr(2'd0, 32'd7);   wr(2'd1, 32'd0);
    wr(2'd0, 32'd33);  wr(2'd1, 32'd3);
    wr(2'd0, 32'd55);  wr(2'd1, 32'd4);
    rd(2'd3); chk("ovf_status", avs_readdata, 32'h40A);
    wr(2'd2, 32'd4);
    rd(2'd3); chk("clr_ovf_status", avs_readdata, 32'h402);
    rd(2'd2); chk("ctrl_readback", avs_readdata, 32'd0);
    wr(2'd2, 32'd1);
    idle(220);
    rd(2'd3); chk("drained_status", avs_readdata, 32'h4);

    // Rest note: period 0, 2 ms.
    wr(2'd0, 32'd0); wr(2'd1, 32'd2);
    measure_busy(hi, lo);
    chk("rest_busy_len", hi, 32'd41);
    chk("rest_enable_cnt", lo, 32'd0);

    // Push coinciding with the pop of a full FIFO.
    wr(2'd2, 32'd2);
    wr(2'd0, 32'd1000); wr(2'd1, 32'd1);
    wr(2'd2, 32'd1);
    wr(2'd1, 32'd1); wr(2'd1, 32'd1); wr(2'd1, 32'd1); wr(2'd1, 32'd1);
    n = 0;
    while (seq_busy && n < 100) begin @(negedge clk); n++; end
    wr(2'd1, 32'd1);
    rd(2'd3); chk("push_pop_full_status", avs_readdata, 32'h403);
    idle(200);

    // Stop mid-tone.
    wr(2'd0, 32'd200); wr(2'd1, 32'd5);
    idle(15);
    chk("midplay_on", 32'(pwm_enable), 32'd1);
    wr(2'd2, 32'd0);
    chk("stop_enable", 32'(pwm_enable), 32'd0);
    chk("stop_busy", 32'(seq_busy), 32'd0);

    // Flush mid-tone.
    wr(2'd0, 32'd300); wr(2'd1, 32'd5); wr(2'd1, 32'd5);
    wr(2'd2, 32'd1);
    idle(15);
    wr(2'd2, 32'd3);
    chk("flush_busy", 32'(seq_busy), 32'd0);
    rd(2'd3); chk("flush_status", avs_readdata, 32'h4);

    // Zero duration plays one tick.
    wr(2'd0, 32'd300); wr(2'd1, 32'd0);
    measure(hi, lo, dv, dt);
    chk("dur0_len", hi, 32'd10);
    chk("dur0_gap", lo, 32'd20);
    chk("dur0_div", dv, 32'd300);
    chk("dur0_duty", dt, 32'd150);

`ifdef BUZZER_SEQ_IRQ_EN
    wr(2'd0, 32'd50); wr(2'd1, 32'd1);
    wr(2'd2, 32'd9);
    idle(40);
    chk("irq_drained", 32'(ins_irq), 32'd1);
    rd(2'd2); chk("ctrl_irq_en", avs_readdata, 32'd9);
    wr(2'd1, 32'd1);
    chk("irq_after_push", 32'(ins_irq), 32'd0);
    idle(40);
    wr(2'd2, 32'd1);
    chk("irq_en_cleared", 32'(ins_irq), 32'd0);
`endif

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
